// File: rtl/bs_pkg.sv
// Shared constants for the Black-Scholes pricing datapath: default word
// format, fixed-point one, FSM state encoding and saturation limits.
package bs_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int FRAC_DEF  = 16;

  localparam logic signed [WIDTH_DEF-1:0] ONE_Q = 32'sd1 <<< FRAC_DEF;

  // Saturation bounds for the default word width
  localparam logic signed [WIDTH_DEF-1:0] SAT_MAX_Q = 32'sh7FFF_FFFF;
  localparam logic signed [WIDTH_DEF-1:0] SAT_MIN_Q = 32'sh8000_0000;

  typedef logic [2:0] bs_state_t;

  localparam bs_state_t ST_IDLE     = 3'd0;
  localparam bs_state_t ST_MUL1     = 3'd1;
  localparam bs_state_t ST_MUL2     = 3'd2;
  localparam bs_state_t ST_MUL3     = 3'd3;
  localparam bs_state_t ST_SUM      = 3'd4;
  localparam bs_state_t ST_COMPLETE = 3'd5;

endpackage

// File: rtl/bs_price_if.sv
// Request/result bundle between the parameter-prep/CDF stages (master)
// and the pricing stage (slave).
interface bs_price_if
  import bs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic                    start;
  logic signed [WIDTH-1:0] S;
  logic signed [WIDTH-1:0] K;
  logic signed [WIDTH-1:0] disc;
  logic signed [WIDTH-1:0] Nd1;
  logic signed [WIDTH-1:0] Nd2;
  logic signed [WIDTH-1:0] call;
  logic signed [WIDTH-1:0] put;
  logic                    err;
  logic                    busy;
  logic                    done;

  modport master (
    output start, S, K, disc, Nd1, Nd2,
    input  call, put, err, busy, done
  );

  modport slave (
    input  start, S, K, disc, Nd1, Nd2,
    output call, put, err, busy, done
  );
endinterface

// File: rtl/fx_mul_sat.sv
// One-cycle registered signed fixed-point multiply: full-width product,
// arithmetic shift by FRAC, then saturate to the WIDTH-bit range.
module fx_mul_sat #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
);
  localparam int PW = 2 * WIDTH;
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0]    PMAX = PW'(MAXV);
  localparam logic signed [PW-1:0]    PMIN = PW'(MINV);

  logic signed [PW-1:0]    prod_s;
  logic signed [PW-1:0]    shr_s;
  logic signed [WIDTH-1:0] sat_s;

  // Product, truncating shift toward -inf, and clamp
  always_comb begin
    prod_s = PW'(a) * PW'(b);
    shr_s  = prod_s >>> FRAC;
    if (shr_s > PMAX) begin
      sat_s = MAXV;
    end else if (shr_s < PMIN) begin
      sat_s = MINV;
    end else begin
      sat_s = shr_s[WIDTH-1:0];
    end
  end

  // Result register, loaded only when a product is requested
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y <= {WIDTH{1'b0}};
    end else if (en) begin
      y <= sat_s;
    end else begin
      y <= y;
    end
  end
endmodule

// File: rtl/bs_price.sv
// Black-Scholes pricing stage: C = S*N(d1) - K*disc*N(d2), P = C - S + K*disc,
// computed with one shared registered multiplier stepped by a small FSM.
module bs_price
  import bs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input logic       clk,
  input logic       reset_n,
  bs_price_if.slave bus
);
  localparam int WW = WIDTH + 2;
  localparam logic signed [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WW-1:0]    WMAX = WW'(MAXV);
  localparam logic signed [WW-1:0]    WMIN = WW'(MINV);

  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [WW-1:0] v);
    logic signed [WIDTH-1:0] r;
    if (v > WMAX) begin
      r = MAXV;
    end else if (v < WMIN) begin
      r = MINV;
    end else begin
      r = v[WIDTH-1:0];
    end
    return r;
  endfunction

  // Negative results only arise from truncation artefacts; a price is never below zero
  function automatic logic signed [WIDTH-1:0] clamp0(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] r;
    if (v[WIDTH-1]) begin
      r = ZERO;
    end else begin
      r = v;
    end
    return r;
  endfunction

  bs_state_t               state_r;
  logic signed [WIDTH-1:0] s_r, k_r, disc_r, nd1_r, nd2_r;
  logic signed [WIDTH-1:0] p1_r, kd_r;
  logic signed [WIDTH-1:0] call_r, put_r;
  logic                    err_r, done_r, busy_r;

  logic                    mul_en_s;
  logic signed [WIDTH-1:0] mul_a_s, mul_b_s, mul_y_s;
  logic                    bad_in_s;
  logic signed [WIDTH-1:0] diff_s, call_s, put_s;
  logic signed [WW-1:0]    diff_w_s, put_w_s;

  assign bad_in_s = bus.S[WIDTH-1] | (bus.S == ZERO) |
                    bus.K[WIDTH-1] | (bus.K == ZERO) |
                    bus.disc[WIDTH-1];

  // Operand steering for the shared multiplier; MUL3 chains kd straight from its output
  always_comb begin
    mul_en_s = 1'b0;
    mul_a_s  = ZERO;
    mul_b_s  = ZERO;
    case (state_r)
      ST_MUL1: begin
        mul_en_s = 1'b1;
        mul_a_s  = s_r;
        mul_b_s  = nd1_r;
      end
      ST_MUL2: begin
        mul_en_s = 1'b1;
        mul_a_s  = k_r;
        mul_b_s  = disc_r;
      end
      ST_MUL3: begin
        mul_en_s = 1'b1;
        mul_a_s  = mul_y_s;
        mul_b_s  = nd2_r;
      end
      default: begin
        mul_en_s = 1'b0;
        mul_a_s  = ZERO;
        mul_b_s  = ZERO;
      end
    endcase
  end

  fx_mul_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (mul_en_s),
    .a       (mul_a_s),
    .b       (mul_b_s),
    .y       (mul_y_s)
  );

  // Final sums in SUM; p2 is the multiplier output at that point
  always_comb begin
    diff_w_s = WW'(p1_r) - WW'(mul_y_s);
    diff_s   = sat_w(diff_w_s);
    put_w_s  = WW'(diff_s) - WW'(s_r) + WW'(kd_r);
    call_s   = clamp0(diff_s);
    put_s    = clamp0(sat_w(put_w_s));
  end

  // Input capture on an accepted request; later input changes are ignored
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_r    <= ZERO;
      k_r    <= ZERO;
      disc_r <= ZERO;
      nd1_r  <= ZERO;
      nd2_r  <= ZERO;
    end else if ((state_r == ST_IDLE) && bus.start) begin
      s_r    <= bus.S;
      k_r    <= bus.K;
      disc_r <= bus.disc;
      nd1_r  <= bus.Nd1;
      nd2_r  <= bus.Nd2;
    end else begin
      s_r    <= s_r;
      k_r    <= k_r;
      disc_r <= disc_r;
      nd1_r  <= nd1_r;
      nd2_r  <= nd2_r;
    end
  end

  // Sequencing FSM with registered results and handshake flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      p1_r    <= ZERO;
      kd_r    <= ZERO;
      call_r  <= ZERO;
      put_r   <= ZERO;
      err_r   <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start && bad_in_s) begin
            call_r  <= ZERO;
            put_r   <= ZERO;
            err_r   <= 1'b1;
            done_r  <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_COMPLETE;
          end else if (bus.start) begin
            err_r   <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_MUL1;
          end else begin
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_MUL1: begin
          state_r <= ST_MUL2;
        end
        ST_MUL2: begin
          p1_r    <= mul_y_s;
          state_r <= ST_MUL3;
        end
        ST_MUL3: begin
          kd_r    <= mul_y_s;
          state_r <= ST_SUM;
        end
        ST_SUM: begin
          call_r  <= call_s;
          put_r   <= put_s;
          done_r  <= 1'b1;
          state_r <= ST_COMPLETE;
        end
        ST_COMPLETE: begin
          if (!bus.start) begin
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_COMPLETE;
          end
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.call = call_r;
  assign bus.put  = put_r;
  assign bus.err  = err_r;
  assign bus.done = done_r;
  assign bus.busy = busy_r;
endmodule

// File: tb/tb_bs_price.sv
// Directed self-checking bench for bs_price; expected values are hand-derived
// from Q16.16 arithmetic on the quantised stimulus.
module tb_bs_price;
  import bs_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  bs_price_if #(.WIDTH(32)) bus ();

  bs_price #(.WIDTH(32), .FRAC(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 100.0, 0.951229 -> 62340, 0.636831 -> 41735, 0.559618 -> 36675 (Q16.16)
  localparam logic signed [31:0] Q100   = 32'sh0064_0000;
  localparam logic signed [31:0] Q50    = 32'sh0032_0000;
  localparam logic signed [31:0] DISC_N = 32'sd62340;
  localparam logic signed [31:0] ND1_N  = 32'sd41735;
  localparam logic signed [31:0] ND2_N  = 32'sd36675;
  // p1 = 4173500, kd = 6234000, p2 = floor(6234000*36675/65536) = 3488646
  localparam int CALL_N = 684854;
  localparam int PUT_N  = 365254;
  localparam logic signed [31:0] Q30000 = 32'sh7530_0000;
  localparam logic signed [31:0] Q2     = 32'sh0002_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic signed [31:0] obs, input int exp);
    int d;
    d = int'(obs) - exp;
    checks++;
    assert ((d <= 4) && (d >= -4)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d +/-4", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic signed [31:0] s, input logic signed [31:0] k,
                       input logic signed [31:0] dsc, input logic signed [31:0] n1,
                       input logic signed [31:0] n2);
    bus.S    = s;
    bus.K    = k;
    bus.disc = dsc;
    bus.Nd1  = n1;
    bus.Nd2  = n2;
  endtask

  // Raise start, then confirm busy on E0..E4 and done only after E4
  task automatic run_valid(input string tag);
    bus.start = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_done"}, 32'(bus.done), (e == 4) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    logic signed [31:0] held_call;
    logic signed [31:0] held_put;
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b1;
    bus.start = 1'b0;
    apply(32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_call", bus.call, 32'h0);
    chk("rst_put",  bus.put,  32'h0);
    chk("rst_err",  32'(bus.err),  32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Nominal at-the-money pricing
    apply(Q100, Q100, DISC_N, ND1_N, ND2_N);
    run_valid("nom");
    chk_near("nom_call", bus.call, CALL_N);
    chk_near("nom_put",  bus.put,  PUT_N);
    chk("nom_err", 32'(bus.err), 32'd0);

    // Start held: result frozen even though inputs change
    held_call = bus.call;
    held_put  = bus.put;
    apply(Q50, Q100, ONE_Q, 32'sd0, 32'sd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_done", 32'(bus.done), 32'd1);
      chk("hold_call", bus.call, held_call);
      chk("hold_put",  bus.put,  held_put);
    end
    bus.start = 1'b0;
    tick();
    chk("drop_done", 32'(bus.done), 32'd0);
    chk("drop_busy", 32'(bus.busy), 32'd0);

    // Zero CDFs: call 0, put = K*disc - S = 50.0
    run_valid("zcdf");
    chk("zcdf_call", bus.call, 32'h0000_0000);
    chk("zcdf_put",  bus.put,  32'h0032_0000);
    bus.start = 1'b0;
    tick();

    // kd saturates; with Nd2=1.0 call = 0 and put = clamp0(-kd - 1.0 + kd) = 0
    apply(ONE_Q, Q30000, Q2, 32'sd0, ONE_Q);
    run_valid("sat1");
    chk("sat1_call", bus.call, 32'h0000_0000);
    chk("sat1_put",  bus.put,  32'h0000_0000);
    bus.start = 1'b0;
    tick();

    // Same kd with Nd2 = 0: put = 0x7FFFFFFF - 1.0, a wrapped kd would give 0
    apply(ONE_Q, Q30000, Q2, 32'sd0, 32'sd0);
    run_valid("sat2");
    chk("sat2_call", bus.call, 32'h0000_0000);
    chk("sat2_put",  bus.put,  32'h7FFE_FFFF);
    bus.start = 1'b0;
    tick();

    // Invalid spot: immediate error completion
    apply(32'sd0, Q100, ONE_Q, ND1_N, ND2_N);
    bus.start = 1'b1;
    tick();
    chk("inv_done", 32'(bus.done), 32'd1);
    chk("inv_err",  32'(bus.err),  32'd1);
    chk("inv_call", bus.call, 32'h0);
    chk("inv_put",  bus.put,  32'h0);
    bus.start = 1'b0;
    tick();
    chk("inv_drop", 32'(bus.done), 32'd0);

    // Valid request after the error clears err
    apply(Q100, Q100, DISC_N, ND1_N, ND2_N);
    run_valid("rec");
    chk("rec_err", 32'(bus.err), 32'd0);
    chk_near("rec_call", bus.call, CALL_N);
    bus.start = 1'b0;
    tick();

    // Reset while in MUL2 clears outputs without waiting for a clock
    apply(Q50, Q100, ONE_Q, 32'sd0, 32'sd0);
    bus.start = 1'b1;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_call", bus.call, 32'h0);
    chk("mrst_put",  bus.put,  32'h0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("mrst_idle", 32'(bus.busy), 32'd0);
    run_valid("post");
    chk("post_call", bus.call, 32'h0000_0000);
    chk("post_put",  bus.put,  32'h0032_0000);
    bus.start = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
